rule_seq_detector: RTL
======================

RULE_SEQ_DETECTOR -- requirements
Module: rule_seq_detector

Interface
REQ-001 Parameter: CNT_W, default 16, width of the match and fail counters.
REQ-002 Port: sysclk  input  1  single clock; all state updates on posedge sysclk.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  when 1, a sampled trans may start a new attempt.
REQ-005 Port: clr  input  1  synchronous clear of counters and in-flight attempts.
REQ-006 Ports: trans, start_trans, a, b, c, end_trans  input  1 each  monitored rule signals.
REQ-007 Port: match  output  1  one-cycle pulse per completed rule.
REQ-008 Port: fail  output  1  one-cycle pulse when at least one attempt died.
REQ-009 Port: fail_stage  output  3  lowest stage index (1..5) that failed this cycle; 0 when fail=0.
REQ-010 Port: match_cnt  output  CNT_W  saturating count of matches.
REQ-011 Port: fail_cnt  output  CNT_W  saturating count of dead attempts.
REQ-012 Port: busy  output  1  1 while any attempt is in flight.

Function
REQ-013 Rule definition: trans ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans, all sampled at posedge sysclk.
REQ-014 Stage k (k=1..5) checks, in order: start_trans, a, b, c, end_trans.
REQ-015 Attempt tracking: token vector tok[1:5]; tok[k]=1 means an attempt awaits its stage-k check this cycle.
REQ-016 Start: trans=1 and en=1 at edge t sets tok[1] at t+1; trans=0 starts nothing and is never a failure.
REQ-017 Advance: tok[k] with stage-k signal 1 sets tok[k+1] at the next edge.
REQ-018 Death: tok[k] with stage-k signal 0 drops the attempt.
REQ-019 Match timing: tok[5] with end_trans=1 at edge t+5 gives match=1 during cycle t+6 (registered, 6-cycle latency from trans).
REQ-020 Fail timing: fail, fail_stage and the fail_cnt update are registered the cycle after the failing check.
REQ-021 Overlap: up to 5 concurrent attempts, one per token; each is evaluated independently.
REQ-022 fail_cnt increments by the popcount of attempts dying that cycle (0..5).
REQ-023 match_cnt increments by 1 per match.
REQ-024 Counters saturate at 2^CNT_W-1; at or near saturation they clamp and never wrap.
REQ-025 en=0 blocks new starts only; in-flight attempts complete or fail normally.
REQ-026 clr=1 zeroes tok, match_cnt and fail_cnt at the next edge.
REQ-027 clr has priority over counting and starts in that cycle; match and fail are 0 in the following cycle.
REQ-028 busy = OR of tok[1:5] (combinational from registers).

Reset
REQ-029 rst=1 asynchronously clears tok, match, fail, fail_stage, match_cnt and fail_cnt to 0.
REQ-030 Reset mid-attempt discards all in-flight attempts with no match or fail pulse.
REQ-031 Sampling of trans resumes at the first edge after rst deasserts.

Configuration
REQ-032 Macro RULE_SEQ_DETECTOR_FAIL_CNT_EN defined: fail_cnt counts per REQ-022.
REQ-033 Macro undefined: fail_cnt is tied to 0 and its counter logic is absent; fail and fail_stage are unaffected.

Structure
REQ-034 Package rule_seq_pkg holds:
- NUM_STAGES=5
- typedef stage_idx_t (3-bit)
- stage enumeration constants STG_START_TRANS..STG_END_TRANS
REQ-035 Sub-module sat_counter (parameterised width, increment input, clear, saturation) is instantiated once per counter.

Verification
REQ-036 Single rule: trans@0, start_trans@1, a@2, b@3, c@4, end_trans@5 -> match=1 at cycle 6 only; match_cnt=1; fail_cnt=0.
REQ-037 Stage-3 failure: as REQ-036 but b=0@3 -> fail=1, fail_stage=3 at cycle 4; match_cnt=0; fail_cnt=1.
REQ-038 Overlap: trans=1 on cycles 0..4, all stage signals held 1 -> match pulses on cycles 6..10; match_cnt=5; busy=1 on cycles 1..9.
REQ-039 Multiple deaths in one cycle: 3 attempts in flight, start_trans=a=b=0 in the same cycle -> fail_stage=1 next cycle; fail_cnt +3 with macro defined, 0 without.
REQ-040 Reset and clear: rst pulse at cycle 3 of an attempt -> no match or fail; separately, clr with match_cnt=7 -> 0 next cycle.
REQ-041 Saturation: CNT_W=2, 5 matches -> match_cnt stays 3.

Source files
------------

// File: rtl/rule_seq_pkg.sv
// -----------------------------------------------------------------------------
// rule_seq_pkg
// Shared definitions for the rule sequence detector:
//   NUM_STAGES    - number of checked stages after the trans start condition
//   stage_idx_t   - 3-bit stage index (0 = no stage, 1..5 = stage number)
//   stage_e       - named stage constants STG_START_TRANS..STG_END_TRANS
//   count_ones    - popcount of a per-stage bit vector
//   lowest_stage  - index of the lowest set stage bit (STG_NONE if none)
// -----------------------------------------------------------------------------
package rule_seq_pkg;

   localparam int NUM_STAGES = 5;

   typedef logic [2:0] stage_idx_t;

   typedef enum logic [2:0] {
      STG_NONE        = 3'd0,
      STG_START_TRANS = 3'd1,
      STG_A           = 3'd2,
      STG_B           = 3'd3,
      STG_C           = 3'd4,
      STG_END_TRANS   = 3'd5
   } stage_e;

   // Number of set bits in a per-stage vector (0..NUM_STAGES).
   function automatic logic [2:0] count_ones(input logic [NUM_STAGES:1] v);
      logic [2:0] n;
      n = 3'd0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
         n = n + {2'b00, v[k]};
      end
      return n;
   endfunction

   // Lowest stage number whose bit is set; scanning downward lets the
   // lowest set index be the last one written.
   function automatic stage_idx_t lowest_stage(input logic [NUM_STAGES:1] v);
      stage_idx_t idx;
      idx = STG_NONE;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (v[k]) begin
            idx = stage_idx_t'(k);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a multi-bit increment. The counter clamps at
// 2^W-1 and never wraps, even when a single increment would overshoot.
// Ports:
//   clk  - clock (posedge)
//   rst  - asynchronous active-high reset, clears the count
//   clr  - synchronous clear, takes priority over the increment
//   inc  - amount to add this cycle (INC_W bits)
//   cnt  - registered count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W     = 16,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [INC_W-1:0] inc,
   output logic [W-1:0]     cnt
);

   // Wide enough that cnt + inc can never overflow before the clamp.
   localparam int SUM_W = W + INC_W;
   localparam logic [SUM_W-1:0] MAX_VAL = {{INC_W{1'b0}}, {W{1'b1}}};

   logic [W-1:0]     cnt_q;
   logic [W-1:0]     cnt_d;
   logic [SUM_W-1:0] sum_s;

   // Next count: clear, clamp at full scale, or add the increment.
   always_comb begin
      sum_s = {{INC_W{1'b0}}, cnt_q} + {{W{1'b0}}, inc};
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (sum_s > MAX_VAL) begin
         cnt_d = {W{1'b1}};
      end else begin
         cnt_d = sum_s[W-1:0];
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/rule_seq_detector.sv
// -----------------------------------------------------------------------------
// rule_seq_detector
// Monitors the rule  trans ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans
// with up to five overlapping attempts. Each in-flight attempt is a token in
// tok_q[1:5]; tok_q[k] means an attempt is waiting for its stage-k check at
// the current edge. Passing tokens shift up, failing tokens are dropped and
// reported, a token passing stage 5 produces a match.
//
// Ports:
//   sysclk      - clock, all state on posedge
//   rst         - asynchronous active-high reset
//   en          - allows a sampled trans to start a new attempt
//   clr         - synchronous clear of counters and in-flight attempts
//   trans, start_trans, a, b, c, end_trans - monitored rule signals
//   match       - one-cycle pulse per completed rule
//   fail        - one-cycle pulse when at least one attempt died
//   fail_stage  - lowest failing stage (1..5) this cycle, 0 when fail=0
//   match_cnt   - saturating match count (CNT_W bits)
//   fail_cnt    - saturating count of dead attempts (CNT_W bits)
//   busy        - any attempt in flight
//
// Build option: define RULE_SEQ_DETECTOR_FAIL_CNT_EN to build the fail
// counter; without it fail_cnt is tied to zero (fail/fail_stage unaffected).
// -----------------------------------------------------------------------------
module rule_seq_detector
   import rule_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             trans,
   input  logic             start_trans,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             end_trans,
   output logic             match,
   output logic             fail,
   output logic [2:0]       fail_stage,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             busy
);

   logic [NUM_STAGES:1] tok_q;
   logic [NUM_STAGES:1] tok_d;
   logic                match_q;
   logic                match_d;
   logic                fail_q;
   logic                fail_d;
   stage_idx_t          fail_stage_q;
   stage_idx_t          fail_stage_d;

   logic [NUM_STAGES:1] stage_sig_s;
   logic [NUM_STAGES:1] tok_die_s;

   // Map each stage number to the signal it checks.
   always_comb begin
      stage_sig_s                  = {NUM_STAGES{1'b0}};
      stage_sig_s[STG_START_TRANS] = start_trans;
      stage_sig_s[STG_A]           = a;
      stage_sig_s[STG_B]           = b;
      stage_sig_s[STG_C]           = c;
      stage_sig_s[STG_END_TRANS]   = end_trans;
   end

   // An attempt dies where a token meets a low stage signal.
   assign tok_die_s = tok_q & ~stage_sig_s;

   // Token advance, start, match and fail evaluation. clr overrides all of it,
   // so a clearing cycle neither starts attempts nor reports results.
   always_comb begin
      tok_d        = tok_q;
      match_d      = 1'b0;
      fail_d       = 1'b0;
      fail_stage_d = STG_NONE;
      if (clr) begin
         tok_d        = {NUM_STAGES{1'b0}};
         match_d      = 1'b0;
         fail_d       = 1'b0;
         fail_stage_d = STG_NONE;
      end else begin
         // Surviving tokens of stages 1..4 move one stage up; a stage-5
         // survivor is a match and leaves the pipeline.
         tok_d        = {tok_q[NUM_STAGES-1:1] & stage_sig_s[NUM_STAGES-1:1],
                         trans & en};
         match_d      = tok_q[NUM_STAGES] & stage_sig_s[NUM_STAGES];
         fail_d       = |tok_die_s;
         fail_stage_d = lowest_stage(tok_die_s);
      end
   end

   // Token pipeline and registered result pulses.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         tok_q        <= {NUM_STAGES{1'b0}};
         match_q      <= 1'b0;
         fail_q       <= 1'b0;
         fail_stage_q <= STG_NONE;
      end else begin
         tok_q        <= tok_d;
         match_q      <= match_d;
         fail_q       <= fail_d;
         fail_stage_q <= fail_stage_d;
      end
   end

   // The match counter steps on the same edge that raises the match pulse.
   sat_counter #(
      .W     (CNT_W),
      .INC_W (1)
   ) u_match_cnt (
      .clk (sysclk),
      .rst (rst),
      .clr (clr),
      .inc (match_d),
      .cnt (match_cnt)
   );

`ifdef RULE_SEQ_DETECTOR_FAIL_CNT_EN
   logic [2:0] fail_inc_s;

   // Several attempts may die on one edge; count every one of them.
   assign fail_inc_s = count_ones(tok_die_s);

   sat_counter #(
      .W     (CNT_W),
      .INC_W (3)
   ) u_fail_cnt (
      .clk (sysclk),
      .rst (rst),
      .clr (clr),
      .inc (fail_inc_s),
      .cnt (fail_cnt)
   );
`else
   assign fail_cnt = {CNT_W{1'b0}};
`endif

   assign match      = match_q;
   assign fail       = fail_q;
   assign fail_stage = fail_stage_q;
   assign busy       = |tok_q;

endmodule
